video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing generator on the HDMI pixel clock. Drives the encoder stage and the
//  GBA line-buffer read side: free-running H/V counters from the resolution package,
//  DE/HSYNC/VSYNC, and GBA source coordinates (240x160) for integer scale S=maxScaleCnt+1,
//  image centred in the frame. Supports re-locking the frame start to the GBA frame.
// PARAMETERS
//  H_FP       88   horizontal front porch, pixels (after FRAMEWIDTH)
//  H_SYNC     44   HSYNC width, pixels
//  V_FP       4    vertical front porch, lines (after FRAMEHEIGHT)
//  V_SYNC     5    VSYNC width, lines
//  SYNC_POL   1    active level of HSYNC/VSYNC (inactive = ~SYNC_POL)
//  widthMax/heightMax/FRAMEWIDTH/FRAMEHEIGHT/maxScaleCnt come from definePackage, not params
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   synchronous, active-high reset
//  frameSync  in   1   1-cycle pulse: restart raster at (0,0)
//  de         out  1   active video (x<FRAMEWIDTH && y<FRAMEHEIGHT)
//  hsync      out  1   horizontal sync, level SYNC_POL when active
//  vsync      out  1   vertical sync, level SYNC_POL when active
//  inImage    out  1   pixel lies inside scaled GBA image window
//  gbaX       out  8   GBA source column 0..239 (valid when inImage)
//  gbaY       out  8   GBA source row 0..159 (valid when inImage)
//  newFrame   out  1   1-cycle pulse for raster position (0,0)
// BEHAVIOUR
//  - Internal x: 12 b, 0..widthMax-1; y: 11 b, 0..heightMax-1. x wraps -> y++; y wraps at heightMax-1.
//  - All outputs registered; outputs at cycle t decode position held at t-1 (1-cycle latency).
//  - Reset: x=y=0, subcounters=0; de=inImage=newFrame=0, gbaX=gbaY=0, hsync=vsync=~SYNC_POL.
//    First cycle after reset release outputs position (0,0): newFrame=1, de=1.
//  - hsync active: FRAMEWIDTH+H_FP <= x < FRAMEWIDTH+H_FP+H_SYNC (1080p: 2008..2051).
//  - vsync active: FRAMEHEIGHT+V_FP <= y < FRAMEHEIGHT+V_FP+V_SYNC (1080p: 1084..1088), line-aligned.
//  - Image window: X_OFF=(FRAMEWIDTH-240*S)/2, Y_OFF=(FRAMEHEIGHT-160*S)/2 (1080p S=6: 240, 60);
//    inImage when X_OFF<=x<X_OFF+240*S and Y_OFF<=y<Y_OFF+160*S.
//  - X scaler: at x==X_OFF clears gbaX and xSub; inside window xSub counts 0..maxScaleCnt,
//    gbaX increments when xSub wraps. Outside window gbaX/xSub hold.
//  - Y scaler: at y==Y_OFF and x==0 clears gbaY and ySub; advances once per line at x==widthMax-1
//    while y inside window; gbaY increments when ySub wraps. gbaY saturates at 159 (never wraps).
//  - frameSync: next position is (0,0), all subcounters cleared, regardless of current position;
//    coincident with natural frame wrap -> same result, single newFrame pulse. Ignored during rst.
//  - rst has priority over frameSync. Reset mid-frame: restart exactly as from power-up.
//  - No backpressure: one position per clk, always.
// STRUCTURE
//  - definePackage gains: H_FP/H_SYNC/V_FP/V_SYNC per resolution, GBA_WIDTH=240,
//    GBA_HEIGHT=160, SCALE=maxScaleCnt+1, X_OFF, Y_OFF, H_CNT_W=12, V_CNT_W=11.
//  - Sub-module scale_counter (clear, advance -> sub 0..maxScaleCnt, 8-b index, saturate at MAX);
//    instantiated twice (X, Y). Top holds raster counters, decode, output registers.
// TESTING (1080p, SCALE6 build)
//  - rst 10 cycles, release -> all outputs at reset values while rst; cycle 1 after: newFrame=1, de=1.
//  - Free run 3 frames -> newFrame period 2,475,000 cycles; de high 1920 cycles/line on 1080 lines.
//  - Line 0 -> hsync high for x 2008..2051 (44 cycles); vsync high for lines 1084..1088 only.
//  - Position (240,60) -> inImage=1, gbaX=0, gbaY=0; (245,60) gbaX=0; (246,60) gbaX=1;
//    (239,60) inImage=0; (1679,1019) gbaX=239, gbaY=159; (1680,1019) inImage=0; line 66 -> gbaY=1.
//  - frameSync at (1000,500) -> next output position (0,0), newFrame=1, gbaY restarts 0 at line 60.
//  - rst at (1500,700) for 1 cycle -> outputs return to reset values, raster restarts at (0,0).

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Raster and scaling constants for the HDMI video timing generator.
// Default build: 1080p60 raster (2200x1125 total, 1920x1080 active) with the
// 240x160 GBA picture scaled by SCALE = maxScaleCnt + 1 and centred in the frame.
package video_timing_gen_pkg;

  // Resolution
  localparam int FRAMEWIDTH  = 1920;
  localparam int FRAMEHEIGHT = 1080;
  localparam int widthMax    = 2200;
  localparam int heightMax   = 1125;

  // Blanking for this resolution
  localparam int DEF_H_FP    = 88;
  localparam int DEF_H_SYNC  = 44;
  localparam int DEF_V_FP    = 4;
  localparam int DEF_V_SYNC  = 5;

  // GBA source picture and integer scale
  localparam int maxScaleCnt = 5;
  localparam int SCALE       = maxScaleCnt + 1;
  localparam int GBA_WIDTH   = 240;
  localparam int GBA_HEIGHT  = 160;

  // Counter widths
  localparam int H_CNT_W     = 12;
  localparam int V_CNT_W     = 11;
  localparam int IDX_W       = 8;

  typedef logic [IDX_W-1:0] idx_t;

  // Left/top offset that centres an img_len*scale picture in frame_len.
  function automatic int center_offset(input int frame_len, input int img_len,
                                       input int scale);
    return (frame_len - img_len * scale) / 2;
  endfunction

  localparam int X_OFF = center_offset(FRAMEWIDTH, GBA_WIDTH, SCALE);
  localparam int Y_OFF = center_offset(FRAMEHEIGHT, GBA_HEIGHT, SCALE);

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing bundle between the raster generator and its consumers
// (encoder stage, GBA line-buffer read side).
//   frameSync : 1-cycle pulse from the consumer side, restart raster at (0,0)
//   de        : active video
//   hsync     : horizontal sync (level SYNC_POL when active)
//   vsync     : vertical sync (level SYNC_POL when active)
//   inImage   : pixel lies inside the scaled GBA window
//   gbaX/gbaY : GBA source column/row for the pixel
//   newFrame  : 1-cycle pulse marking raster position (0,0)
// modport master: the generator; modport slave: a consumer.
interface video_timing_gen_if;
  import video_timing_gen_pkg::*;

  logic frameSync;
  logic de;
  logic hsync;
  logic vsync;
  logic inImage;
  idx_t gbaX;
  idx_t gbaY;
  logic newFrame;

  modport master (
    input  frameSync,
    output de, hsync, vsync, inImage, gbaX, gbaY, newFrame
  );

  modport slave (
    output frameSync,
    input  de, hsync, vsync, inImage, gbaX, gbaY, newFrame
  );
endinterface

// File: rtl/video_timing_gen_scale_counter.sv
// Integer down-scaler index counter. A sub-counter runs 0..SCALE_N-1 on each
// advance; the index steps when the sub-counter wraps and stops at IDX_MAX.
// The registered state is the source index for the raster position the top
// currently holds.
//   clk, rst : pixel clock, synchronous active-high reset
//   clear    : restart sub-counter and index at 0 (priority over advance)
//   advance  : step the sub-counter once
//   idx      : current source index
module video_timing_gen_scale_counter
  import video_timing_gen_pkg::*;
#(
  parameter int SCALE_N = SCALE,
  parameter int IDX_MAX = GBA_WIDTH - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output idx_t idx
);

  localparam int SUB_W = (SCALE_N > 1) ? $clog2(SCALE_N) : 1;
  typedef logic [SUB_W-1:0] sub_t;
  localparam sub_t SUB_LAST = sub_t'(SCALE_N - 1);
  localparam idx_t IDX_LAST = idx_t'(IDX_MAX);

  sub_t sub;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sub <= '0;
      idx <= '0;
    end else if (advance) begin
      if (sub == SUB_LAST) begin
        sub <= '0;
        if (idx != IDX_LAST) idx <= idx + idx_t'(1);
      end else begin
        sub <= sub + sub_t'(1);
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator on the HDMI pixel clock. Free-running H/V counters
// produce DE/HSYNC/VSYNC plus GBA source coordinates for an integer-scaled,
// centred 240x160 picture. All outputs are registered: the outputs in a cycle
// describe the raster position held in the previous cycle.
//   clk : pixel clock
//   rst : synchronous active-high reset (priority over frameSync)
//   vid : video_timing_gen_if master (frameSync in; de, hsync, vsync,
//         inImage, gbaX, gbaY, newFrame out)
// Geometry defaults to the package resolution; the overrides exist so the
// same RTL can be built for other rasters.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int FRAME_W    = FRAMEWIDTH,
  parameter int FRAME_H    = FRAMEHEIGHT,
  parameter int WIDTH_MAX  = widthMax,
  parameter int HEIGHT_MAX = heightMax,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter bit SYNC_POL   = 1'b1,
  parameter int IMG_W      = GBA_WIDTH,
  parameter int IMG_H      = GBA_HEIGHT,
  parameter int IMG_SCALE  = SCALE
) (
  input  logic                clk,
  input  logic                rst,
  video_timing_gen_if.master  vid
);

  typedef logic [H_CNT_W-1:0] hcnt_t;
  typedef logic [V_CNT_W-1:0] vcnt_t;

  localparam int IMG_X0 = center_offset(FRAME_W, IMG_W, IMG_SCALE);
  localparam int IMG_Y0 = center_offset(FRAME_H, IMG_H, IMG_SCALE);

  localparam hcnt_t X_LAST = hcnt_t'(WIDTH_MAX - 1);
  localparam vcnt_t Y_LAST = vcnt_t'(HEIGHT_MAX - 1);
  localparam hcnt_t X_ACT  = hcnt_t'(FRAME_W);
  localparam vcnt_t Y_ACT  = vcnt_t'(FRAME_H);
  localparam hcnt_t HS_ON  = hcnt_t'(FRAME_W + H_FP);
  localparam hcnt_t HS_OFF = hcnt_t'(FRAME_W + H_FP + H_SYNC);
  localparam vcnt_t VS_ON  = vcnt_t'(FRAME_H + V_FP);
  localparam vcnt_t VS_OFF = vcnt_t'(FRAME_H + V_FP + V_SYNC);
  localparam hcnt_t IX_ON  = hcnt_t'(IMG_X0);
  localparam hcnt_t IX_OFF = hcnt_t'(IMG_X0 + IMG_W * IMG_SCALE);
  localparam vcnt_t IY_ON  = vcnt_t'(IMG_Y0);
  localparam vcnt_t IY_OFF = vcnt_t'(IMG_Y0 + IMG_H * IMG_SCALE);

  hcnt_t x_p0;
  vcnt_t y_p0;
  hcnt_t x_nxt;
  vcnt_t y_nxt;
  logic  line_end;
  logic  x_clr, x_adv, y_clr, y_adv;
  idx_t  x_idx, y_idx;

  logic  de_p1, hsync_p1, vsync_p1, in_image_p1, new_frame_p1;
  idx_t  gba_x_p1, gba_y_p1;

  // Stage p0: raster position and scaler state for the position held now.
  // The scalers are steered by the position about to be entered, so their
  // state always matches x_p0/y_p0.
  always_comb begin
    line_end = (x_p0 == X_LAST);
    x_nxt    = line_end ? '0 : x_p0 + hcnt_t'(1);
    y_nxt    = y_p0;
    if (line_end) y_nxt = (y_p0 == Y_LAST) ? '0 : y_p0 + vcnt_t'(1);
    if (vid.frameSync) begin
      x_nxt = '0;
      y_nxt = '0;
    end

    x_clr = vid.frameSync || (x_nxt == IX_ON);
    x_adv = (x_nxt > IX_ON) && (x_nxt < IX_OFF);
    y_clr = vid.frameSync || ((x_nxt == '0) && (y_nxt == IY_ON));
    y_adv = line_end && (y_p0 >= IY_ON) && (y_p0 < IY_OFF);
  end

  video_timing_gen_scale_counter #(
    .SCALE_N (IMG_SCALE),
    .IDX_MAX (IMG_W - 1)
  ) u_x_scale (
    .clk     (clk),
    .rst     (rst),
    .clear   (x_clr),
    .advance (x_adv),
    .idx     (x_idx)
  );

  video_timing_gen_scale_counter #(
    .SCALE_N (IMG_SCALE),
    .IDX_MAX (IMG_H - 1)
  ) u_y_scale (
    .clk     (clk),
    .rst     (rst),
    .clear   (y_clr),
    .advance (y_adv),
    .idx     (y_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_p0         <= '0;
      y_p0         <= '0;
      de_p1        <= 1'b0;
      hsync_p1     <= ~SYNC_POL;
      vsync_p1     <= ~SYNC_POL;
      in_image_p1  <= 1'b0;
      gba_x_p1     <= '0;
      gba_y_p1     <= '0;
      new_frame_p1 <= 1'b0;
    end else begin
      x_p0         <= x_nxt;
      y_p0         <= y_nxt;
      // Stage p1: decode of the p0 position.
      de_p1        <= (x_p0 < X_ACT) && (y_p0 < Y_ACT);
      hsync_p1     <= ((x_p0 >= HS_ON) && (x_p0 < HS_OFF)) ? SYNC_POL : ~SYNC_POL;
      vsync_p1     <= ((y_p0 >= VS_ON) && (y_p0 < VS_OFF)) ? SYNC_POL : ~SYNC_POL;
      in_image_p1  <= (x_p0 >= IX_ON) && (x_p0 < IX_OFF) &&
                      (y_p0 >= IY_ON) && (y_p0 < IY_OFF);
      gba_x_p1     <= x_idx;
      gba_y_p1     <= y_idx;
      new_frame_p1 <= (x_p0 == '0) && (y_p0 == '0);
    end
  end

  assign vid.de       = de_p1;
  assign vid.hsync    = hsync_p1;
  assign vid.vsync    = vsync_p1;
  assign vid.inImage  = in_image_p1;
  assign vid.gbaX     = gba_x_p1;
  assign vid.gbaY     = gba_y_p1;
  assign vid.newFrame = new_frame_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. One instance uses the default 1080p
// build (reset, release and line-0 timing); a second instance uses a small
// raster (40x24 total, 30x16 active, 8x4 source picture at scale 3,
// active-low syncs) so whole frames, frameSync and mid-frame reset are cheap.
// Small-raster derived values: image x 3..26, y 2..13; hsync x 33..36;
// vsync lines 18..20; frame length 960 cycles.
module tb_video_timing_gen;
  import video_timing_gen_pkg::*;

  localparam int SW     = 40;
  localparam int SH     = 24;
  localparam int SFRAME = SW * SH;

  logic clk = 1'b0;
  logic rst_hd;
  logic rst_sm;
  int   checks = 0;
  int   errors = 0;
  int   sm_lin = 0;

  always #5 clk = ~clk;

  video_timing_gen_if vid_hd ();
  video_timing_gen_if vid_sm ();

  video_timing_gen dut_hd (
    .clk (clk),
    .rst (rst_hd),
    .vid (vid_hd)
  );

  video_timing_gen #(
    .FRAME_W    (30),
    .FRAME_H    (16),
    .WIDTH_MAX  (SW),
    .HEIGHT_MAX (SH),
    .H_FP       (3),
    .H_SYNC     (4),
    .V_FP       (2),
    .V_SYNC     (3),
    .SYNC_POL   (1'b0),
    .IMG_W      (8),
    .IMG_H      (4),
    .IMG_SCALE  (3)
  ) dut_sm (
    .clk (clk),
    .rst (rst_sm),
    .vid (vid_sm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_sm();
    @(negedge clk);
    sm_lin++;
  endtask

  // Advance until the small DUT's outputs describe position (x,y).
  task automatic sm_to(input int x, input int y);
    int tgt;
    int n;
    tgt = y * SW + x;
    n   = 0;
    while (((sm_lin % SFRAME) != tgt) && (n < 2 * SFRAME)) begin
      step_sm();
      n++;
    end
    if (n >= 2 * SFRAME) begin
      errors++;
      $display("FAIL reach_%0d_%0d: position not reached within %0d cycles", x, y, n);
    end
  endtask

  task automatic chk_sm_reset(input string tag);
    chk({tag, "_de"},       vid_sm.de,       1'b0);
    chk({tag, "_hsync"},    vid_sm.hsync,    1'b1);
    chk({tag, "_vsync"},    vid_sm.vsync,    1'b1);
    chk({tag, "_inImage"},  vid_sm.inImage,  1'b0);
    chk({tag, "_gbaX"},     vid_sm.gbaX,     8'd0);
    chk({tag, "_gbaY"},     vid_sm.gbaY,     8'd0);
    chk({tag, "_newFrame"}, vid_sm.newFrame, 1'b0);
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last, de_cnt, vs_cnt, nf_cnt;
    int nf_first, nf_last, img_cnt, model_err;
    int p, x, y;
    logic e_de, e_hs, e_vs, e_img;

    rst_hd = 1'b1;
    rst_sm = 1'b1;
    vid_hd.frameSync = 1'b0;
    vid_sm.frameSync = 1'b0;
    repeat (10) @(negedge clk);

    // ---------------- 1080p instance ----------------
    chk("hd_rst_de",       vid_hd.de,       1'b0);
    chk("hd_rst_hsync",    vid_hd.hsync,    1'b0);
    chk("hd_rst_vsync",    vid_hd.vsync,    1'b0);
    chk("hd_rst_inImage",  vid_hd.inImage,  1'b0);
    chk("hd_rst_gbaX",     vid_hd.gbaX,     8'd0);
    chk("hd_rst_gbaY",     vid_hd.gbaY,     8'd0);
    chk("hd_rst_newFrame", vid_hd.newFrame, 1'b0);

    rst_hd = 1'b0;
    @(negedge clk);
    chk("hd_first_newFrame", vid_hd.newFrame, 1'b1);
    chk("hd_first_de",       vid_hd.de,       1'b1);
    chk("hd_first_inImage",  vid_hd.inImage,  1'b0);

    hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; vs_cnt = 0; nf_cnt = 0;
    for (int i = 0; i < 2200; i++) begin
      if (vid_hd.hsync === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (vid_hd.de === 1'b1) de_cnt++;
      if (vid_hd.vsync === 1'b1) vs_cnt++;
      if (vid_hd.newFrame === 1'b1) nf_cnt++;
      @(negedge clk);
    end
    chk("hd_line0_hsync_cycles", hs_cnt,   44);
    chk("hd_line0_hsync_first",  hs_first, 2008);
    chk("hd_line0_hsync_last",   hs_last,  2051);
    chk("hd_line0_de_cycles",    de_cnt,   1920);
    chk("hd_line0_vsync_cycles", vs_cnt,   0);
    chk("hd_line0_newFrame",     nf_cnt,   1);
    chk("hd_line1_de",           vid_hd.de,       1'b1);
    chk("hd_line1_newFrame",     vid_hd.newFrame, 1'b0);

    // ---------------- small-raster instance ----------------
    chk_sm_reset("sm_rst");
    rst_sm = 1'b0;
    @(negedge clk);
    sm_lin = 0;
    chk("sm_first_newFrame", vid_sm.newFrame, 1'b1);
    chk("sm_first_de",       vid_sm.de,       1'b1);
    chk("sm_first_hsync",    vid_sm.hsync,    1'b1);
    chk("sm_first_vsync",    vid_sm.vsync,    1'b1);

    // Three free-running frames against a positional model.
    nf_cnt = 0; nf_first = -1; nf_last = -1; de_cnt = 0; hs_cnt = 0;
    vs_cnt = 0; img_cnt = 0; model_err = 0;
    for (int i = 0; i < 3 * SFRAME; i++) begin
      p = sm_lin % SFRAME;
      x = p % SW;
      y = p / SW;
      e_de  = (x < 30) && (y < 16);
      e_hs  = !((x >= 33) && (x < 37));
      e_vs  = !((y >= 18) && (y < 21));
      e_img = (x >= 3) && (x < 27) && (y >= 2) && (y < 14);
      if (vid_sm.newFrame === 1'b1) begin
        nf_cnt++;
        if (nf_first < 0) nf_first = i;
        nf_last = i;
      end
      if (vid_sm.de === 1'b1) de_cnt++;
      if (vid_sm.hsync === 1'b0) hs_cnt++;
      if (vid_sm.vsync === 1'b0) vs_cnt++;
      if (vid_sm.inImage === 1'b1) img_cnt++;
      if ((vid_sm.de !== e_de) || (vid_sm.hsync !== e_hs) ||
          (vid_sm.vsync !== e_vs) || (vid_sm.inImage !== e_img)) model_err++;
      if (e_img && ((vid_sm.gbaX !== 8'((x - 3) / 3)) || (vid_sm.gbaY !== 8'((y - 2) / 3))))
        model_err++;
      step_sm();
    end
    chk("sm_run_newFrame_pulses", nf_cnt, 3);
    chk("sm_run_newFrame_first",  nf_first, 0);
    chk("sm_run_newFrame_span",   nf_last - nf_first, 2 * SFRAME);
    chk("sm_run_de_cycles",       de_cnt, 1440);
    chk("sm_run_hsync_cycles",    hs_cnt, 288);
    chk("sm_run_vsync_cycles",    vs_cnt, 360);
    chk("sm_run_image_cycles",    img_cnt, 864);
    chk("sm_run_model_errors",    model_err, 0);

    // Directed positions.
    sm_to(2, 2);   chk("sm_2_2_inImage", vid_sm.inImage, 1'b0);
    sm_to(3, 2);   chk("sm_3_2_inImage", vid_sm.inImage, 1'b1);
                   chk("sm_3_2_gbaX",    vid_sm.gbaX,    8'd0);
                   chk("sm_3_2_gbaY",    vid_sm.gbaY,    8'd0);
    sm_to(5, 2);   chk("sm_5_2_gbaX",    vid_sm.gbaX,    8'd0);
    sm_to(6, 2);   chk("sm_6_2_gbaX",    vid_sm.gbaX,    8'd1);
    sm_to(3, 4);   chk("sm_3_4_gbaY",    vid_sm.gbaY,    8'd0);
    sm_to(3, 5);   chk("sm_3_5_gbaY",    vid_sm.gbaY,    8'd1);
    sm_to(26, 13); chk("sm_26_13_gbaX",  vid_sm.gbaX,    8'd7);
                   chk("sm_26_13_gbaY",  vid_sm.gbaY,    8'd3);
                   chk("sm_26_13_inImage", vid_sm.inImage, 1'b1);
    sm_to(27, 13); chk("sm_27_13_inImage", vid_sm.inImage, 1'b0);
    sm_to(0, 14);  chk("sm_0_14_gbaY_sat", vid_sm.gbaY,  8'd3);
    sm_to(3, 14);  chk("sm_3_14_inImage", vid_sm.inImage, 1'b0);
    sm_to(32, 14); chk("sm_32_14_hsync", vid_sm.hsync,   1'b1);
    sm_to(33, 14); chk("sm_33_14_hsync", vid_sm.hsync,   1'b0);
    sm_to(29, 15); chk("sm_29_15_de",    vid_sm.de,      1'b1);
    sm_to(30, 15); chk("sm_30_15_de",    vid_sm.de,      1'b0);
    sm_to(0, 16);  chk("sm_0_16_de",     vid_sm.de,      1'b0);
    sm_to(39, 17); chk("sm_39_17_vsync", vid_sm.vsync,   1'b1);
    sm_to(0, 18);  chk("sm_0_18_vsync",  vid_sm.vsync,   1'b0);
    sm_to(39, 20); chk("sm_39_20_vsync", vid_sm.vsync,   1'b0);
    sm_to(0, 21);  chk("sm_0_21_vsync",  vid_sm.vsync,   1'b1);
    sm_to(0, 0);   chk("sm_wrap_newFrame", vid_sm.newFrame, 1'b1);

    // frameSync while the raster holds (10,7).
    sm_to(9, 7);
    vid_sm.frameSync = 1'b1;
    step_sm();
    vid_sm.frameSync = 1'b0;
    chk("sync_10_7_inImage",  vid_sm.inImage,  1'b1);
    chk("sync_10_7_gbaX",     vid_sm.gbaX,     8'd2);
    chk("sync_10_7_gbaY",     vid_sm.gbaY,     8'd1);
    chk("sync_10_7_newFrame", vid_sm.newFrame, 1'b0);
    @(negedge clk);
    sm_lin = 0;
    chk("sync_restart_newFrame", vid_sm.newFrame, 1'b1);
    chk("sync_restart_de",       vid_sm.de,       1'b1);
    chk("sync_restart_gbaX",     vid_sm.gbaX,     8'd0);
    chk("sync_restart_gbaY",     vid_sm.gbaY,     8'd0);
    step_sm();
    chk("sync_1_0_newFrame",     vid_sm.newFrame, 1'b0);
    sm_to(3, 2);   chk("sync_3_2_gbaY", vid_sm.gbaY, 8'd0);
                   chk("sync_3_2_gbaX", vid_sm.gbaX, 8'd0);
    sm_to(3, 5);   chk("sync_3_5_gbaY", vid_sm.gbaY, 8'd1);

    // frameSync coincident with the natural frame wrap.
    sm_to(38, 23);
    vid_sm.frameSync = 1'b1;
    step_sm();
    vid_sm.frameSync = 1'b0;
    chk("cwrap_39_23_newFrame", vid_sm.newFrame, 1'b0);
    step_sm();
    chk("cwrap_0_0_newFrame",   vid_sm.newFrame, 1'b1);
    step_sm();
    chk("cwrap_1_0_newFrame",   vid_sm.newFrame, 1'b0);

    // Reset mid-frame, with a frameSync that must be ignored.
    sm_to(15, 8);
    rst_sm = 1'b1;
    vid_sm.frameSync = 1'b1;
    @(negedge clk);
    chk_sm_reset("midrst");
    rst_sm = 1'b0;
    vid_sm.frameSync = 1'b0;
    @(negedge clk);
    sm_lin = 0;
    chk("midrst_newFrame", vid_sm.newFrame, 1'b1);
    chk("midrst_de",       vid_sm.de,       1'b1);
    sm_to(3, 2);   chk("midrst_3_2_inImage", vid_sm.inImage, 1'b1);
                   chk("midrst_3_2_gbaX",    vid_sm.gbaX,    8'd0);
    sm_to(6, 5);   chk("midrst_6_5_gbaX",    vid_sm.gbaX,    8'd1);
                   chk("midrst_6_5_gbaY",    vid_sm.gbaY,    8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
